truth_table_capture: RTL and testbench

Response-side end of the counter-driven test flow. The 3-bit counter sweeps minterm indices into a combinational function under test. This block samples the pair (index, function output) on each valid cycle and assembles the full 2^N_IN-row truth table. Once every row is seen, it compares the table against an expected constant and reports pass/fail, the error count and the lowest failing row.

---
 rtl/ttc_pkg.sv | 21 ++
 rtl/ttc_popcount.sv | 15 +
 rtl/truth_table_capture.sv | 112 +++++++++++
 tb/tb_truth_table_capture.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared types and constants for the truth-table capture block.
package ttc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } ttc_state_e;

  localparam int TTC_N_IN = 3;

  // Expected tables for the two reference functions, bit i = minterm i.
  localparam logic [7:0] TTC_EXP_P1 = 8'h0E;
  localparam logic [7:0] TTC_EXP_P2 = 8'hE8;

  function automatic int ttc_rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/ttc_popcount.sv
// Population count of a W-bit vector; result wide enough to hold W.
module ttc_popcount #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(vec[i]);
  end

endmodule

// File: rtl/truth_table_capture.sv
// Captures (index, bit) samples into a truth table and checks it against EXP_TABLE.
// Optional per-sample mismatch pulse on sample_err when TTC_STREAM_CHECK_EN is defined.
module truth_table_capture
  import ttc_pkg::*;
#(
  parameter int              N_IN      = TTC_N_IN,
  parameter int              ROWS      = ttc_rows(N_IN),
  parameter logic [ROWS-1:0] EXP_TABLE = ROWS'(TTC_EXP_P1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_idx,
  input  logic            in_bit,
  output logic            busy,
  output logic [ROWS-1:0] table_o,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_idx,
  output logic            sample_err
);

  ttc_state_e      state, state_nxt;
  logic [ROWS-1:0] table_q, seen_q, diff;
  logic [N_IN:0]   pc;
  logic [N_IN-1:0] fe_c;

  assign table_o = table_q;
  assign diff    = table_q ^ EXP_TABLE;

  ttc_popcount #(.W(ROWS), .CW(N_IN + 1)) u_pop (
    .vec (diff),
    .cnt (pc)
  );

  always_comb begin
    fe_c = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (diff[i]) fe_c = N_IN'(i);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Completion is judged on the registered seen mask, so CHECK starts one
  // cycle after the last new row lands and done rises two edges after it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (start) state_nxt = CAPTURE;
               else if (&seen_q) state_nxt = CHECK;
      CHECK:   state_nxt = start ? CAPTURE : DONE;
      DONE:    if (start) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CAPTURE, CHECK: busy = 1'b1;
      DONE:           done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      table_q       <= '0;
      seen_q        <= '0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (start) begin
      table_q       <= '0;
      seen_q        <= '0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      case (state)
        CAPTURE: if (in_valid) begin
          table_q[in_idx] <= in_bit;
          seen_q[in_idx]  <= 1'b1;
        end
        CHECK: begin
          pass          <= (diff == '0);
          err_cnt       <= pc;
          first_err_idx <= fe_c;
        end
        default: ;
      endcase
    end
  end

`ifdef TTC_STREAM_CHECK_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) sample_err <= 1'b0;
    else      sample_err <= !start && (state == CAPTURE) && in_valid &&
                            (in_bit != EXP_TABLE[in_idx]);
  end
`else
  assign sample_err = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture with default parameters (EXP_TABLE = 8'h0E).
module tb_truth_table_capture;
  logic       clk = 1'b0;
  logic       clr, start, in_valid, in_bit;
  logic [2:0] in_idx;
  logic       busy, done, pass, sample_err;
  logic [7:0] table_o;
  logic [3:0] err_cnt;
  logic [2:0] first_err_idx;
  int total = 0, bad = 0;

  truth_table_capture dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_idx(in_idx),
    .in_bit(in_bit), .busy(busy), .table_o(table_o), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .sample_err(sample_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] i, input logic b);
    in_idx = i; in_bit = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_idx = '0; in_bit = 1'b0;
    #12;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
    total++; if (table_o !== 8'h00) begin bad++; $display("FAIL reset_table got=%h want 00", table_o); end
    total++; if (pass !== 1'b0 || err_cnt !== 4'd0 || first_err_idx !== 3'd0 || sample_err !== 1'b0) begin
      bad++; $display("FAIL reset_results pass=%b err=%0d fe=%0d se=%b want 0 0 0 0", pass, err_cnt, first_err_idx, sample_err); end
    @(negedge clk); clr = 1'b1;
    tick();
  endtask

  task automatic test_p1_sweep();
    logic [7:0] v;
    v = 8'h0E;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL p1_busy got=%b want 1", busy); end
    for (int i = 0; i < 8; i++) send(3'(i), v[i]);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL p1_done_k got=%b want 0", done); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL p1_check_cycle done=%b busy=%b want 0 1", done, busy); end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL p1_done_k2 done=%b busy=%b want 1 0", done, busy); end
    total++; if (table_o !== 8'h0E) begin bad++; $display("FAIL p1_table got=%h want 0e", table_o); end
    total++; if (pass !== 1'b1 || err_cnt !== 4'd0 || first_err_idx !== 3'd0) begin
      bad++; $display("FAIL p1_result pass=%b err=%0d fe=%0d want 1 0 0", pass, err_cnt, first_err_idx); end
  endtask

  task automatic test_p2_sweep();
    logic [7:0] v, se_exp;
    v = 8'hE8;
    se_exp = 8'hE6;
    pulse_start();
    total++; if (done !== 1'b0 || table_o !== 8'h00) begin bad++; $display("FAIL p2_start_clear done=%b table=%h want 0 00", done, table_o); end
    for (int i = 0; i < 8; i++) begin
      send(3'(i), v[i]);
`ifdef TTC_STREAM_CHECK_EN
      total++; if (sample_err !== se_exp[i]) begin bad++; $display("FAIL p2_sample_err idx=%0d got=%b want %b", i, sample_err, se_exp[i]); end
`else
      total++; if (sample_err !== 1'b0) begin bad++; $display("FAIL p2_sample_err_off idx=%0d got=%b want 0 (se_exp=%b)", i, sample_err, se_exp[i]); end
`endif
    end
    tick(); tick();
    total++; if (done !== 1'b1 || table_o !== 8'hE8) begin bad++; $display("FAIL p2_table done=%b table=%h want 1 e8", done, table_o); end
    total++; if (pass !== 1'b0 || err_cnt !== 4'd5 || first_err_idx !== 3'd1) begin
      bad++; $display("FAIL p2_result pass=%b err=%0d fe=%0d want 0 5 1", pass, err_cnt, first_err_idx); end
  endtask

  task automatic test_order_dup();
    pulse_start();
    send(3'd5, 1'b0); send(3'd2, 1'b0); send(3'd2, 1'b1); send(3'd7, 1'b0);
    send(3'd0, 1'b0); send(3'd1, 1'b1); send(3'd3, 1'b1); send(3'd6, 1'b0);
    tick(); tick(); tick();
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL order_no_early_done done=%b busy=%b want 0 1", done, busy); end
    send(3'd4, 1'b0);
    tick(); tick();
    total++; if (done !== 1'b1 || table_o[2] !== 1'b1) begin bad++; $display("FAIL order_done done=%b bit2=%b want 1 1", done, table_o[2]); end
    total++; if (table_o !== 8'h0E || pass !== 1'b1) begin bad++; $display("FAIL order_table table=%h pass=%b want 0e 1", table_o, pass); end
  endtask

  task automatic test_clr_mid();
    pulse_start();
    send(3'd0, 1'b1); send(3'd1, 1'b1); send(3'd2, 1'b1); send(3'd3, 1'b1);
    #2 clr = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || table_o !== 8'h00) begin
      bad++; $display("FAIL clr_async busy=%b done=%b table=%h want 0 0 00", busy, done, table_o); end
    @(negedge clk); clr = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'b1);
    tick(); tick();
    total++; if (busy !== 1'b0 || done !== 1'b0 || table_o !== 8'h00) begin
      bad++; $display("FAIL clr_idle_ignore busy=%b done=%b table=%h want 0 0 00", busy, done, table_o); end
  endtask

  task automatic test_start_with_valid();
    logic [7:0] v;
    v = 8'h0E;
    pulse_start();
    for (int i = 0; i < 5; i++) send(3'(i), 1'b1);
    start = 1'b1;
    send(3'd5, 1'b1);
    start = 1'b0;
    total++; if (table_o !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL sv_drop table=%h busy=%b want 00 1", table_o, busy); end
    for (int i = 0; i < 7; i++) send(3'(i), v[i]);
    tick(); tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sv_partial_done got=%b want 0", done); end
    send(3'd7, v[7]);
    tick(); tick();
    total++; if (done !== 1'b1 || table_o !== 8'h0E || pass !== 1'b1) begin
      bad++; $display("FAIL sv_full done=%b table=%h pass=%b want 1 0e 1", done, table_o, pass); end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 8; i++) send(3'(i), ~in_bit);
    send(3'd1, 1'b0); send(3'd4, 1'b1);
    total++; if (done !== 1'b1 || table_o !== 8'h0E || pass !== 1'b1 || err_cnt !== 4'd0) begin
      bad++; $display("FAIL done_hold done=%b table=%h pass=%b err=%0d want 1 0e 1 0", done, table_o, pass, err_cnt); end
    pulse_start();
    total++; if (done !== 1'b0 || busy !== 1'b1 || table_o !== 8'h00 || pass !== 1'b0) begin
      bad++; $display("FAIL done_restart done=%b busy=%b table=%h pass=%b want 0 1 00 0", done, busy, table_o, pass); end
  endtask

  initial begin
    test_reset();
    test_p1_sweep();
    test_p2_sweep();
    test_order_dup();
    test_clr_mid();
    test_start_with_valid();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
